// File: rtl/mem_bus_master.sv
// Burst initiator for a single-port memory with one-cycle registered reads
// and one-cycle writes. A client posts a read or write burst (start word
// address, length); the engine walks the address range, wrapping modulo
// MEM_DEPTH, and owns the Mem_Bus drive only during its own write cycles.
module mem_bus_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              RW,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              DONE,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  localparam int MA_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, WR_DRAIN, FIN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  rem;      // read: addresses left to issue; write: words left to accept
  logic [MA_W-1:0]   addr_q;   // address presented to the memory
  logic [MA_W-1:0]   nxt_q;    // address the next accepted write word will use
  logic [DATA_W-1:0] wdata_q;  // word driven onto Mem_Bus during a write cycle
  logic              rd_pend;  // memory is returning a word this cycle
  logic [LEN_W-1:0]  eff_len;

  // Address bits above the memory depth never reach the bus.
  logic unused_addr_hi;
  assign unused_addr_hi = ^START_ADDR[ADDR_W-1:MA_W];

  // Requested lengths beyond the burst limit are clamped.
  assign eff_len = (LEN > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN;

  assign ADDR = ADDR_W'(addr_q);

  // Drive the shared bus only in our own write cycles; otherwise release it
  // so the memory can return read data without contention.
  assign Mem_Bus = (CS && WE) ? wdata_q : {DATA_W{1'bz}};

  // Burst sequencer: state, registered memory strobes and client handshakes.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking '=' would let later statements see half-updated state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      rem     <= '0;
      addr_q  <= '0;
      nxt_q   <= '0;
      // NOTE: the write-data register is reset too, so the bus value is
      // never undefined; it is a single word, not a memory array.
      wdata_q <= '0;
      rd_pend <= 1'b0;
      BUSY    <= 1'b0;
      WREADY  <= 1'b0;
      RDATA   <= '0;
      RVALID  <= 1'b0;
      DONE    <= 1'b0;
      CS      <= 1'b0;
      WE      <= 1'b0;
    end else begin
      // The memory answers one cycle after a read strobe.
      rd_pend <= (state == RD);
      if (rd_pend) begin
        RDATA  <= Mem_Bus;
        RVALID <= 1'b1;
      end else begin
        RVALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (REQ) begin
            BUSY <= 1'b1;
            if (eff_len == '0) begin
              // Zero-length bursts pass through the empty drain slot so
              // completion timing matches a real burst.
              state <= WR_DRAIN;
            end else if (RW) begin
              state  <= WR;
              WREADY <= 1'b1;
              rem    <= eff_len;
              nxt_q  <= START_ADDR[MA_W-1:0];
            end else begin
              state  <= RD;
              CS     <= 1'b1;
              WE     <= 1'b0;
              addr_q <= START_ADDR[MA_W-1:0];
              rem    <= eff_len - 1'b1;
            end
          end
        end

        RD: begin
          if (rem == '0) begin
            state <= RD_LAST;
          end else begin
            addr_q <= addr_q + 1'b1;
            rem    <= rem - 1'b1;
          end
        end

        RD_LAST: begin
          CS    <= 1'b0;
          DONE  <= 1'b1;
          state <= FIN;
        end

        WR: begin
          if (WVALID) begin
            wdata_q <= WDATA;
            CS      <= 1'b1;
            WE      <= 1'b1;
            addr_q  <= nxt_q;
            nxt_q   <= nxt_q + 1'b1;
            rem     <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              WREADY <= 1'b0;
              state  <= WR_DRAIN;
            end
          end else begin
            CS <= 1'b0;
            WE <= 1'b0;
          end
        end

        WR_DRAIN: begin
          CS    <= 1'b0;
          WE    <= 1'b0;
          DONE  <= 1'b1;
          state <= FIN;
        end

        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural single-port memory
// (registered read, one-cycle write) sharing the tri-state data bus.
module tb_mem_bus_master;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ, RW, WVALID;
  logic [31:0] START_ADDR, WDATA;
  logic [4:0]  LEN;
  logic        BUSY, WREADY, RVALID, DONE, CS, WE;
  logic [31:0] RDATA, ADDR;
  wire  [31:0] mem_bus;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_d [16];
  logic [31:0] wd    [16];

  mem_bus_master dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .RW(RW), .START_ADDR(START_ADDR),
    .LEN(LEN), .BUSY(BUSY), .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .RDATA(RDATA), .RVALID(RVALID), .DONE(DONE), .CS(CS), .WE(WE),
    .ADDR(ADDR), .Mem_Bus(mem_bus)
  );

  always #5 CLK = ~CLK;

  // Memory model with a preload port for the bench.
  logic [31:0] mem [128];
  logic [31:0] mem_q;
  logic        mem_oe = 1'b0;
  logic        pl_en = 1'b0;
  logic [6:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge CLK) begin
    mem_oe <= CS && !WE;
    if (CS && !WE) mem_q <= mem[ADDR[6:0]];
    if (CS && WE) mem[ADDR[6:0]] <= mem_bus;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  assign mem_bus = mem_oe ? mem_q : {32{1'bz}};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bus_released();
    return (mem_bus === {32{1'bz}}) || (mem_bus === 32'h0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge; returns in cycle 1 of the burst.
  task automatic start_burst(input logic rw, input logic [31:0] a, input logic [4:0] len);
    REQ = 1'b1; RW = rw; START_ADDR = a; LEN = len;
    tick();
    REQ = 1'b0;
  endtask

  // Read burst of l effective words; exp_d holds the expected data.
  task automatic run_read(input logic [31:0] a, input logic [4:0] len, input int l, input bit poke);
    int n_rv = 0;
    start_burst(1'b0, a, len);
    for (int c = 1; c <= l + 2; c++) begin
      if (poke && c == 2) begin REQ = 1'b1; RW = 1'b1; LEN = 5'd2; end
      else REQ = 1'b0;
      check("rd_busy", BUSY, 1'b1);
      check("rd_cs", CS, c <= l + 1);
      check("rd_we", WE, 1'b0);
      if (c <= l + 1)
        check("rd_addr", ADDR, (a + ((c <= l) ? c - 1 : l - 1)) % 128);
      check("rd_rvalid", RVALID, c >= 3);
      if (c >= 3) begin
        check("rd_data", RDATA, exp_d[c-3]);
        n_rv++;
      end
      check("rd_done", DONE, c == l + 2);
      tick();
    end
    REQ = 1'b0;
    check("rd_words", n_rv, l);
    check("rd_idle_busy", BUSY, 1'b0);
    check("rd_idle_rvalid", RVALID, 1'b0);
    check("rd_idle_done", DONE, 1'b0);
    if (l > 0) check("rd_hold", RDATA, exp_d[l-1]);
  endtask

  // Write burst with WVALID held high; wd holds the words.
  task automatic run_write(input logic [31:0] a, input int l);
    start_burst(1'b1, a, 5'(l));
    for (int c = 1; c <= l + 2; c++) begin
      WVALID = (c <= l);
      WDATA  = (c <= l) ? wd[c-1] : 32'h0;
      check("wr_busy", BUSY, 1'b1);
      check("wr_wready", WREADY, c <= l);
      check("wr_cs", CS, (c >= 2) && (c <= l + 1));
      if (c >= 2 && c <= l + 1) begin
        check("wr_we", WE, 1'b1);
        check("wr_addr", ADDR, (a + c - 2) % 128);
        check("wr_bus", mem_bus, wd[c-2]);
      end else begin
        check("wr_bus_z", bus_released(), 1'b1);
      end
      check("wr_done", DONE, c == l + 2);
      tick();
    end
    WVALID = 1'b0;
    check("wr_idle_busy", BUSY, 1'b0);
  endtask

  // Gapped write: L=3 at 0x20 with WVALID pattern 1,0,0,1,1.
  task automatic gap_write();
    bit pat    [7] = '{1, 0, 0, 1, 1, 0, 0};
    bit e_cs   [7] = '{0, 1, 0, 0, 1, 1, 0};
    bit e_rdy  [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit e_done [7] = '{0, 0, 0, 0, 0, 0, 1};
    int hs = 0;
    int nw = 0;
    start_burst(1'b1, 32'h20, 5'd3);
    for (int c = 0; c < 7; c++) begin
      WVALID = pat[c];
      WDATA  = (hs < 3) ? wd[hs] : 32'h0;
      check("gap_wready", WREADY, e_rdy[c]);
      check("gap_cs", CS, e_cs[c]);
      check("gap_done", DONE, e_done[c]);
      if (e_cs[c]) begin
        check("gap_we", WE, 1'b1);
        check("gap_addr", ADDR, 32'h20 + nw);
        check("gap_bus", mem_bus, wd[nw]);
        nw++;
      end
      if (pat[c] && e_rdy[c]) hs++;
      tick();
    end
    WVALID = 1'b0;
    check("gap_idle_busy", BUSY, 1'b0);
  endtask

  initial begin
    RST_N = 1'b0; REQ = 1'b0; RW = 1'b0; START_ADDR = '0; LEN = '0;
    WDATA = '0; WVALID = 1'b0;

    // Preload the memory during reset.
    for (int i = 0; i < 128; i++) begin
      pl_en = 1'b1; pl_addr = 7'(i); pl_data = 32'hC0DE_0000 | i;
      case (i)
        'h7E: pl_data = 32'hAAAA_AAAA;
        'h7F: pl_data = 32'hBBBB_BBBB;
        'h00: pl_data = 32'hCCCC_CCCC;
        'h01: pl_data = 32'hDDDD_DDDD;
        default: ;
      endcase
      tick();
    end
    pl_en = 1'b0;

    // Reset state.
    check("rst_busy", BUSY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_cs", CS, 1'b0);
    check("rst_we", WE, 1'b0);
    check("rst_addr", ADDR, 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_bus_z", bus_released(), 1'b1);
    #3 RST_N = 1'b1;
    tick();
    check("post_rst_busy", BUSY, 1'b0);

    // Single write then single read.
    wd[0] = 32'hDEAD_BEEF;
    run_write(32'h05, 1);
    check("mem_05", mem[5], 32'hDEAD_BEEF);
    exp_d[0] = 32'hDEAD_BEEF;
    run_read(32'h05, 5'd1, 1, 1'b0);

    // Wrapping read burst across the top of memory.
    exp_d[0] = 32'hAAAA_AAAA; exp_d[1] = 32'hBBBB_BBBB;
    exp_d[2] = 32'hCCCC_CCCC; exp_d[3] = 32'hDDDD_DDDD;
    run_read(32'h7E, 5'd4, 4, 1'b0);

    // Write with bubbles, then read back.
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
    gap_write();
    exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h2222_2222; exp_d[2] = 32'h3333_3333;
    run_read(32'h20, 5'd3, 3, 1'b0);

    // Zero-length burst: DONE in cycle 2, no bus activity.
    start_burst(1'b1, 32'h10, 5'd0);
    check("len0_c1_busy", BUSY, 1'b1);
    check("len0_c1_cs", CS, 1'b0);
    check("len0_c1_wready", WREADY, 1'b0);
    check("len0_c1_done", DONE, 1'b0);
    tick();
    check("len0_c2_done", DONE, 1'b1);
    check("len0_c2_cs", CS, 1'b0);
    tick();
    check("len0_c3_busy", BUSY, 1'b0);
    check("len0_c3_done", DONE, 1'b0);

    // Over-long request clamps to 16 words.
    for (int k = 0; k < 16; k++) exp_d[k] = 32'hC0DE_0030 + k;
    run_read(32'h30, 5'd31, 16, 1'b0);

    // REQ during a read burst is ignored and not queued.
    exp_d[0] = 32'hAAAA_AAAA; exp_d[1] = 32'hBBBB_BBBB;
    exp_d[2] = 32'hCCCC_CCCC; exp_d[3] = 32'hDDDD_DDDD;
    run_read(32'h7E, 5'd4, 4, 1'b1);
    tick();
    check("ign_busy", BUSY, 1'b0);
    check("ign_cs", CS, 1'b0);
    check("ign_wready", WREADY, 1'b0);

    // Abort an 8-word write with reset in cycle 4.
    start_burst(1'b1, 32'h40, 5'd8);
    for (int c = 1; c <= 4; c++) begin
      WVALID = 1'b1; WDATA = 32'hA000_0040 + c - 1;
      if (c < 4) tick();
    end
    check("abort_pre_cs", CS, 1'b1);
    #3 RST_N = 1'b0;
    #1;
    check("abort_cs", CS, 1'b0);
    check("abort_we", WE, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    check("abort_wready", WREADY, 1'b0);
    check("abort_addr", ADDR, 32'h0);
    check("abort_bus_z", bus_released(), 1'b1);
    WVALID = 1'b0;
    tick(); tick();
    #3 RST_N = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("abort_no_done", DONE, 1'b0);
      check("abort_no_cs", CS, 1'b0);
    end
    check("abort_mem_41", mem[7'h41], 32'hA000_0041);
    check("abort_mem_42", mem[7'h42], 32'hC0DE_0042);

    // Next request after abort completes normally.
    wd[0] = 32'h5A5A_0001; wd[1] = 32'h5A5A_0002;
    run_write(32'h50, 2);
    exp_d[0] = 32'h5A5A_0001; exp_d[1] = 32'h5A5A_0002;
    run_read(32'h50, 5'd2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
